// File: rtl/rtl_bigreg_writer.sv
// Publishes a wide RTL value into consecutive mem-map entries (LS word first), then sets the
// valid entry and holds off further publications until the PS acknowledges the read.
module rtl_bigreg_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int WORD_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int BASE_ID    = 27
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] val_in,
    input  logic                  val_valid,
    output logic                  wr_en,
    output logic [ID_WIDTH-1:0]   wr_id,
    output logic [WORD_WIDTH-1:0] wr_data,
    input  logic                  wr_ack,
    input  logic                  ps_read_ack,
    output logic                  busy,
    output logic [15:0]           drop_count
);

    localparam int N_WORDS = DATA_WIDTH / WORD_WIDTH;
    localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_WORDS - 1);
    localparam logic [ID_WIDTH-1:0] BASE     = ID_WIDTH'(BASE_ID);
    localparam logic [ID_WIDTH-1:0] VALID_ID = ID_WIDTH'(BASE_ID + N_WORDS);

    generate
        if (DATA_WIDTH % WORD_WIDTH != 0) begin : g_bad_width
            $error("rtl_bigreg_writer: DATA_WIDTH must be a multiple of WORD_WIDTH");
        end
        if (BASE_ID + N_WORDS >= (1 << ID_WIDTH)) begin : g_bad_id
            $error("rtl_bigreg_writer: valid entry index does not fit in ID_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        WORDS,
        VALID,
        WAIT_PS
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pend_q, pend_d;
    logic                    pend_v_q, pend_v_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]        word_idx_q, word_idx_d;
    logic [15:0]             drop_count_q, drop_count_d;
    logic                    consume;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            shift_q      <= '0;
            word_idx_q   <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            shift_q      <= shift_d;
            word_idx_q   <= word_idx_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        pend_v_d     = pend_v_q;
        shift_d      = shift_q;
        word_idx_d   = word_idx_q;
        drop_count_d = drop_count_q;
        consume      = (state_q == IDLE) && pend_v_q;

        case (state_q)
            IDLE: begin
                // The shift register takes its own copy so later producer values cannot tear a publication.
                if (pend_v_q) begin
                    state_d    = WORDS;
                    shift_d    = pend_q;
                    word_idx_d = '0;
                    pend_v_d   = 1'b0;
                end
            end
            WORDS: begin
                if (wr_ack) begin
                    if (word_idx_q == LAST_IDX) begin
                        state_d = VALID;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                        shift_d    = shift_q >> WORD_WIDTH;
                    end
                end
            end
            VALID: begin
                if (wr_ack) begin
                    state_d = WAIT_PS;
                end
            end
            WAIT_PS: begin
                if (ps_read_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A newer value always replaces the pending one; it only counts as a drop if that slot was still unpublished.
        if (val_valid) begin
            pend_d   = val_in;
            pend_v_d = 1'b1;
            if (pend_v_q && !consume && (drop_count_q != 16'hFFFF)) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_id   = '0;
        wr_data = '0;
        case (state_q)
            WORDS: begin
                wr_en   = 1'b1;
                wr_id   = BASE + ID_WIDTH'(word_idx_q);
                wr_data = shift_q[WORD_WIDTH-1:0];
            end
            VALID: begin
                wr_en   = 1'b1;
                wr_id   = VALID_ID;
                wr_data = WORD_WIDTH'(1);
            end
            default: begin
                wr_en   = 1'b0;
                wr_id   = '0;
                wr_data = '0;
            end
        endcase
    end

    assign busy       = (state_q != IDLE) || pend_v_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_rtl_bigreg_writer.sv
// Scoreboard bench for rtl_bigreg_writer: a slot-level reference model queues the expected
// mem-map writes, and a monitor checks every presented write and status output against it.
module tb_rtl_bigreg_writer;

    localparam int DATA_WIDTH = 32;
    localparam int WORD_WIDTH = 16;
    localparam int ID_WIDTH   = 8;
    localparam int BASE_ID    = 27;
    localparam int N_WORDS    = DATA_WIDTH / WORD_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [DATA_WIDTH-1:0] val_in = '0;
    logic                  val_valid = 1'b0;
    logic                  wr_en;
    logic [ID_WIDTH-1:0]   wr_id;
    logic [WORD_WIDTH-1:0] wr_data;
    logic                  wr_ack = 1'b0;
    logic                  ps_read_ack = 1'b0;
    logic                  busy;
    logic [15:0]           drop_count;

    typedef struct {
        logic [ID_WIDTH-1:0]   id;
        logic [WORD_WIDTH-1:0] data;
        bit                    is_valid;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int write_count = 0;

    bit              m_free = 1'b1;
    bit              m_in_wait = 1'b0;
    bit              m_pend_v = 1'b0;
    logic [31:0]     m_pend = '0;
    int              m_drop = 0;
    bit              valid_ack_seen = 1'b0;

    rtl_bigreg_writer #(
        .DATA_WIDTH(DATA_WIDTH),
        .WORD_WIDTH(WORD_WIDTH),
        .ID_WIDTH  (ID_WIDTH),
        .BASE_ID   (BASE_ID)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .val_in     (val_in),
        .val_valid  (val_valid),
        .wr_en      (wr_en),
        .wr_id      (wr_id),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .ps_read_ack(ps_read_ack),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock of stimulus: inputs change just after the rising edge and hold for the whole cycle.
    task automatic applyStimulus(input bit v, input logic [31:0] d, input bit ack, input bit ps);
        @(posedge clk);
        #1;
        val_valid   = v;
        val_in      = d;
        wr_ack      = ack;
        ps_read_ack = ps;
    endtask

    task automatic wait_for_wait_ps(input int budget);
        int n = 0;
        while (!m_in_wait && n < budget) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
            n++;
        end
        checkOutput("wait_ps_reached", {31'b0, m_in_wait}, 32'd1);
    endtask

    task automatic ps_ack();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    // Reference model: one pending slot plus a publisher that is either free, publishing, or
    // waiting for the PS. Each accepted publication queues its words and the valid-entry write.
    always @(posedge clk) begin
        bit consume;
        if (rst) begin
            m_free         = 1'b1;
            m_in_wait      = 1'b0;
            m_pend_v       = 1'b0;
            m_drop         = 0;
            valid_ack_seen = 1'b0;
            exp_q.delete();
        end else begin
            consume = m_free && m_pend_v;
            if (m_in_wait && ps_read_ack) begin
                m_in_wait = 1'b0;
                m_free    = 1'b1;
            end
            if (valid_ack_seen) begin
                m_in_wait      = 1'b1;
                valid_ack_seen = 1'b0;
            end
            if (consume) begin
                for (int k = 0; k < N_WORDS; k++) begin
                    exp_q.push_back('{id: ID_WIDTH'(BASE_ID + k),
                                      data: WORD_WIDTH'(m_pend >> (WORD_WIDTH * k)),
                                      is_valid: 1'b0});
                end
                exp_q.push_back('{id: ID_WIDTH'(BASE_ID + N_WORDS), data: WORD_WIDTH'(1), is_valid: 1'b1});
                m_free = 1'b0;
            end
            if (val_valid) begin
                if (m_pend_v && !consume && m_drop < 65535) m_drop++;
                m_pend   = val_in;
                m_pend_v = 1'b1;
            end else if (consume) begin
                m_pend_v = 1'b0;
            end
        end
    end

    // Monitor: every presented write must match the head of the expected queue; status outputs
    // are compared against the model every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got id=%0d data=0x%0h, expected no write at %0t",
                             wr_id, wr_data, $time);
                end else begin
                    checkOutput("wr_id", {24'b0, wr_id}, {24'b0, exp_q[0].id});
                    checkOutput("wr_data", {16'b0, wr_data}, {16'b0, exp_q[0].data});
                    if (wr_ack) begin
                        if (exp_q[0].is_valid) valid_ack_seen = 1'b1;
                        void'(exp_q.pop_front());
                        write_count++;
                    end
                end
            end
            checkOutput("busy", {31'b0, busy}, {31'b0, (!m_free || m_pend_v)});
            checkOutput("drop_count", {16'b0, drop_count}, 32'(m_drop));
            if (m_free || m_in_wait) checkOutput("wr_en_idle", {31'b0, wr_en}, 32'd0);
        end
    end

    initial begin
        logic [31:0] v;
        int          w0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_wr_en", {31'b0, wr_en}, 32'd0);
        checkOutput("reset_wr_id", {24'b0, wr_id}, 32'd0);
        checkOutput("reset_wr_data", {16'b0, wr_data}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_drop", {16'b0, drop_count}, 32'd0);

        $display("[TB] single value with latency");
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t1_lat_wr_en", {31'b0, wr_en}, 32'd0);
        checkOutput("t1_busy_pending", {31'b0, busy}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t1_w0_en", {31'b0, wr_en}, 32'd1);
        checkOutput("t1_w0_id", {24'b0, wr_id}, 32'd27);
        checkOutput("t1_w0_data", {16'b0, wr_data}, 32'hBEEF);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t1_w1_id", {24'b0, wr_id}, 32'd28);
        checkOutput("t1_w1_data", {16'b0, wr_data}, 32'hDEAD);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t1_valid_id", {24'b0, wr_id}, 32'd29);
        checkOutput("t1_valid_data", {16'b0, wr_data}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t1_done_wr_en", {31'b0, wr_en}, 32'd0);
        checkOutput("t1_wait_busy", {31'b0, busy}, 32'd1);
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t1_still_busy", {31'b0, busy}, 32'd1);
        ps_ack();
        @(negedge clk);
        checkOutput("t1_released", {31'b0, busy}, 32'd0);

        $display("[TB] stall on word1");
        v  = $urandom;
        w0 = write_count;
        applyStimulus(1'b1, v, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("t2_hold_id", {24'b0, wr_id}, 32'd28);
            checkOutput("t2_hold_data", {16'b0, wr_data}, {16'b0, v[31:16]});
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t2_write_count", 32'(write_count - w0), 32'd3);
        wait_for_wait_ps(10);

        $display("[TB] overrun while waiting for PS");
        applyStimulus(1'b1, 32'h1, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h2, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h3, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t3_drop", {16'b0, drop_count}, 32'd2);
        ps_ack();
        wait_for_wait_ps(20);
        ps_ack();

        $display("[TB] value arriving in the consume cycle");
        applyStimulus(1'b1, $urandom, 1'b1, 1'b0);
        applyStimulus(1'b1, $urandom, 1'b1, 1'b0);
        wait_for_wait_ps(20);
        checkOutput("t4_no_drop", {16'b0, drop_count}, 32'd2);
        ps_ack();
        wait_for_wait_ps(20);
        ps_ack();

        $display("[TB] reset during word1");
        applyStimulus(1'b1, $urandom, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t5_at_word1", {24'b0, wr_id}, 32'd28);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_rst_wr_en", {31'b0, wr_en}, 32'd0);
        checkOutput("t5_rst_drop", {16'b0, drop_count}, 32'd0);
        checkOutput("t5_rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        w0 = write_count;
        applyStimulus(1'b1, $urandom, 1'b1, 1'b0);
        wait_for_wait_ps(20);
        checkOutput("t5_full_publish", 32'(write_count - w0), 32'd3);
        ps_ack();

        $display("[TB] drop counter saturation");
        applyStimulus(1'b1, $urandom, 1'b1, 1'b0);
        wait_for_wait_ps(20);
        for (int i = 0; i < 70000; i++) applyStimulus(1'b1, $urandom, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t6_saturated", {16'b0, drop_count}, 32'hFFFF);
        ps_ack();
        wait_for_wait_ps(20);
        ps_ack();

        $display("[TB] randomized traffic");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 5) == 0), $urandom, ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < 500; i++) begin
            if (m_free && !m_pend_v && exp_q.size() == 0) break;
            applyStimulus(1'b0, 32'h0, 1'b1, m_in_wait);
        end
        @(negedge clk);
        checkOutput("drain_complete", {31'b0, (m_free && !m_pend_v && exp_q.size() == 0)}, 32'd1);
        checkOutput("final_busy", {31'b0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
